// File: rtl/dma_rd_streamer.sv
// Read-side DMA streamer: splits one (address, byte count) descriptor into AXI4 INCR read
// requests. Optional abort support is enabled by defining DMA_RD_STREAMER_ABORT_EN.
module dma_rd_streamer #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 512,
  parameter int unsigned MAX_BEATS = 256,
  parameter int unsigned LEN_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef DMA_RD_STREAMER_ABORT_EN
  input  logic                  abort_i,
  output logic                  aborted_o,
`endif
  input  logic                  start_i,
  input  logic [ADDR_W-1:0]     src_addr_i,
  input  logic [LEN_W-1:0]      num_bytes_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  req_valid_o,
  output logic [ADDR_W-1:0]     req_addr_o,
  output logic [7:0]            req_alen_o,
  output logic [2:0]            req_size_o,
  output logic [DATA_W/8-1:0]   req_strb_o,
  input  logic                  req_ready_i
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(BYTES);
  localparam logic [LEN_W-1:0] BYTES_L = LEN_W'(BYTES);
  localparam logic [LEN_W-1:0] MAX_L   = LEN_W'(MAX_BEATS);

  typedef enum logic [1:0] {StIdle, StCalc, StReq} state_e;

  state_e              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [LEN_W-1:0]    r_rem;
  logic [LEN_W-1:0]    r_consumed;
  logic                r_busy;
  logic                r_done;
  logic                r_valid;
  logic [ADDR_W-1:0]   r_req_addr;
  logic [7:0]          r_alen;
  logic [BYTES-1:0]    r_strb;
`ifdef DMA_RD_STREAMER_ABORT_EN
  logic                r_abort_pend;
  logic                r_aborted;
`endif

  logic [OFF_W-1:0]    w_off;
  logic [LEN_W-1:0]    w_off_l;
  logic                w_is_beat;
  logic [LEN_W-1:0]    w_room;
  logic [LEN_W-1:0]    w_beat_bytes;
  logic [LEN_W-1:0]    w_beat_end;
  logic [BYTES-1:0]    w_strb;
  logic [12:0]         w_page_bytes;
  logic [LEN_W-1:0]    w_page_beats;
  logic [LEN_W-1:0]    w_len_beats;
  logic [LEN_W-1:0]    w_beats_a;
  logic [LEN_W-1:0]    w_beats;
  logic [LEN_W-1:0]    w_body_bytes;
  logic [ADDR_W-1:0]   w_aligned;

  // Partial beat: head (unaligned start) or tail (fewer than a full beat left).
  assign w_off        = r_addr[OFF_W-1:0];
  assign w_off_l      = LEN_W'(w_off);
  assign w_is_beat    = (w_off != '0) || (r_rem < BYTES_L);
  assign w_room       = BYTES_L - w_off_l;
  assign w_beat_bytes = (r_rem < w_room) ? r_rem : w_room;
  assign w_beat_end   = w_off_l + w_beat_bytes;

  always_comb begin
    w_strb = '0;
    for (int i = 0; i < BYTES; i++) begin
      w_strb[i] = (LEN_W'(i) >= w_off_l) && (LEN_W'(i) < w_beat_end);
    end
  end

  // Full-width burst limited by bytes left, MAX_BEATS and the distance to the 4 KB page end.
  assign w_page_bytes = 13'd4096 - {1'b0, r_addr[11:0]};
  assign w_page_beats = LEN_W'(w_page_bytes >> OFF_W);
  assign w_len_beats  = r_rem >> OFF_W;
  assign w_beats_a    = (w_len_beats < MAX_L) ? w_len_beats : MAX_L;
  assign w_beats      = (w_page_beats < w_beats_a) ? w_page_beats : w_beats_a;
  assign w_body_bytes = w_beats << OFF_W;
  assign w_aligned    = {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_addr       <= '0;
      r_rem        <= '0;
      r_consumed   <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_valid      <= 1'b0;
      r_req_addr   <= '0;
      r_alen       <= '0;
      r_strb       <= '0;
`ifdef DMA_RD_STREAMER_ABORT_EN
      r_abort_pend <= 1'b0;
      r_aborted    <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
`ifdef DMA_RD_STREAMER_ABORT_EN
      r_aborted <= 1'b0;
`endif
      case (r_state)
        StIdle: begin
          if (start_i) begin
            if (num_bytes_i == '0) begin
              r_done <= 1'b1;
            end else begin
              r_addr  <= src_addr_i;
              r_rem   <= num_bytes_i;
              r_busy  <= 1'b1;
              r_state <= StCalc;
`ifdef DMA_RD_STREAMER_ABORT_EN
              r_abort_pend <= 1'b0;
`endif
            end
          end
        end
        StCalc: begin
`ifdef DMA_RD_STREAMER_ABORT_EN
          if (abort_i) begin
            r_busy    <= 1'b0;
            r_aborted <= 1'b1;
            r_state   <= StIdle;
          end else
`endif
          begin
            r_req_addr <= w_aligned;
            r_valid    <= 1'b1;
            r_state    <= StReq;
            if (w_is_beat) begin
              r_alen     <= 8'd0;
              r_strb     <= w_strb;
              r_consumed <= w_beat_bytes;
            end else begin
              r_alen     <= 8'(w_beats - LEN_W'(1));
              r_strb     <= '1;
              r_consumed <= w_body_bytes;
            end
          end
        end
        StReq: begin
          if (req_ready_i) begin
            r_valid <= 1'b0;
            r_addr  <= r_addr + ADDR_W'(r_consumed);
            r_rem   <= r_rem - r_consumed;
`ifdef DMA_RD_STREAMER_ABORT_EN
            if (r_abort_pend || abort_i) begin
              r_busy       <= 1'b0;
              r_aborted    <= 1'b1;
              r_abort_pend <= 1'b0;
              r_state      <= StIdle;
            end else
`endif
            if (r_rem == r_consumed) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= StIdle;
            end else begin
              r_state <= StCalc;
            end
          end
`ifdef DMA_RD_STREAMER_ABORT_EN
          else if (abort_i) begin
            r_abort_pend <= 1'b1;
          end
`endif
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign req_valid_o = r_valid;
  assign req_addr_o  = r_req_addr;
  assign req_alen_o  = r_alen;
  assign req_size_o  = 3'(OFF_W);
  assign req_strb_o  = r_strb;
`ifdef DMA_RD_STREAMER_ABORT_EN
  assign aborted_o   = r_aborted;
`endif

endmodule

// File: tb/tb_dma_rd_streamer.sv
// Bench for dma_rd_streamer: descriptor-level request model with per-cycle output comparison.
module tb_dma_rd_streamer;

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned DATA_W    = 512;
  localparam int unsigned MAX_BEATS = 256;
  localparam int unsigned LEN_W     = 32;
  localparam int unsigned BYTES     = DATA_W / 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start_i = 1'b0;
  logic [31:0]       src_addr_i = '0;
  logic [31:0]       num_bytes_i = '0;
  logic              req_ready_i = 1'b0;
  logic              busy_o, done_o, req_valid_o;
  logic [31:0]       req_addr_o;
  logic [7:0]        req_alen_o;
  logic [2:0]        req_size_o;
  logic [BYTES-1:0]  req_strb_o;
`ifdef DMA_RD_STREAMER_ABORT_EN
  logic              abort_i = 1'b0;
  logic              aborted_o;
`endif

  dma_rd_streamer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BEATS(MAX_BEATS), .LEN_W(LEN_W)
  ) dut (
    .clk(clk),
    .rst(rst),
`ifdef DMA_RD_STREAMER_ABORT_EN
    .abort_i(abort_i),
    .aborted_o(aborted_o),
`endif
    .start_i(start_i),
    .src_addr_i(src_addr_i),
    .num_bytes_i(num_bytes_i),
    .busy_o(busy_o),
    .done_o(done_o),
    .req_valid_o(req_valid_o),
    .req_addr_o(req_addr_o),
    .req_alen_o(req_alen_o),
    .req_size_o(req_size_o),
    .req_strb_o(req_strb_o),
    .req_ready_i(req_ready_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Expected request list of the descriptor in flight.
  logic [31:0] q_addr[$];
  logic [7:0]  q_alen[$];
  logic [63:0] q_strb[$];
  // Expected phase for the current cycle: 0 idle, 1 between requests, 2 request valid.
  int          m_phase = 0;
  bit          m_done = 1'b0;
  bit          m_next_done;
  bit          model_en = 1'b0;
  int          rdy_mode = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_q();
    q_addr.delete();
    q_alen.delete();
    q_strb.delete();
  endtask

  task automatic gen_reqs(input logic [31:0] addr, input logic [31:0] n);
    logic [31:0]     a;
    longint unsigned rem, off, take, beats, page;
    logic [63:0]     m;
    a = addr;
    rem = n;
    while (rem > 0) begin
      off = a % BYTES;
      m = '0;
      if (off != 0 || rem < BYTES) begin
        take = (BYTES - off < rem) ? BYTES - off : rem;
        for (longint unsigned b = off; b < off + take; b++) m[b] = 1'b1;
        q_alen.push_back(8'd0);
      end else begin
        beats = rem / BYTES;
        if (beats > MAX_BEATS) beats = MAX_BEATS;
        page = (4096 - (a % 4096)) / BYTES;
        if (page < beats) beats = page;
        take = beats * BYTES;
        m = '1;
        q_alen.push_back(8'(beats - 1));
      end
      q_addr.push_back(a & ~32'(BYTES - 1));
      q_strb.push_back(m);
      a = a + 32'(take);
      rem = rem - take;
    end
  endtask

  // Compare this cycle's outputs, then advance the model with this cycle's inputs.
  initial forever begin
    @(negedge clk);
    if (model_en) begin
      chk("busy", busy_o, m_phase != 0);
      chk("done", done_o, m_done);
      chk("valid", req_valid_o, m_phase == 2);
      chk("size", req_size_o, 3'd6);
      if (m_phase == 2 && q_addr.size() > 0) begin
        chk("addr", req_addr_o, q_addr[0]);
        chk("alen", req_alen_o, q_alen[0]);
        chk("strb", req_strb_o, q_strb[0]);
      end
      if (rst) begin
        m_phase = 0;
        m_done = 1'b0;
        clear_q();
      end else begin
        m_next_done = 1'b0;
        case (m_phase)
          0: if (start_i) begin
            if (num_bytes_i == 0) m_next_done = 1'b1;
            else begin
              gen_reqs(src_addr_i, num_bytes_i);
              m_phase = 1;
            end
          end
          1: m_phase = 2;
          default: if (req_ready_i) begin
            void'(q_addr.pop_front());
            void'(q_alen.pop_front());
            void'(q_strb.pop_front());
            if (q_addr.size() == 0) begin
              m_phase = 0;
              m_next_done = 1'b1;
            end else m_phase = 1;
          end
        endcase
        m_done = m_next_done;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    start_i = 1'b0;
    case (rdy_mode)
      0: req_ready_i = 1'b1;
      1: req_ready_i = ($urandom_range(0, 9) < 7);
      default: ;
    endcase
  endtask

  task automatic wait_idle(input int budget, input bit inject);
    int n = 0;
    while (m_phase != 0 && n < budget) begin
      step();
      n++;
      // A start while busy must be ignored.
      if (inject && m_phase != 0 && $urandom_range(0, 7) == 0) begin
        start_i = 1'b1;
        src_addr_i = $urandom;
        num_bytes_i = $urandom_range(0, 500);
      end
    end
    if (m_phase != 0) begin
      checks++;
      failures++;
      $display("FAIL timeout: transfer still active after %0d cycles, required idle", budget);
    end
  endtask

  task automatic run_desc(input logic [31:0] addr, input logic [31:0] n, input bit inject);
    src_addr_i = addr;
    num_bytes_i = n;
    start_i = 1'b1;
    step();
    wait_idle(4000, inject);
  endtask

  initial begin
    logic [31:0] a, n;
    int k;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_valid", req_valid_o, 1'b0);
    chk("rst_addr", req_addr_o, 32'h0);
    chk("rst_alen", req_alen_o, 8'h0);
    chk("rst_strb", req_strb_o, 64'h0);
    chk("rst_size", req_size_o, 3'd6);
    rst = 1'b0;
    model_en = 1'b1;

    // Pin the model against hand-computed request lists.
    gen_reqs(32'h1000, 32'd4096);
    chk("pin_a_n", q_addr.size(), 1);
    chk("pin_a_addr", q_addr[0], 32'h1000);
    chk("pin_a_alen", q_alen[0], 8'd63);
    chk("pin_a_strb", q_strb[0], 64'hFFFF_FFFF_FFFF_FFFF);
    clear_q();
    gen_reqs(32'h1F80, 32'd256);
    chk("pin_b_n", q_addr.size(), 2);
    chk("pin_b_addr0", q_addr[0], 32'h1F80);
    chk("pin_b_alen0", q_alen[0], 8'd1);
    chk("pin_b_addr1", q_addr[1], 32'h2000);
    chk("pin_b_alen1", q_alen[1], 8'd1);
    clear_q();
    gen_reqs(32'h1010, 32'd100);
    chk("pin_c_n", q_addr.size(), 2);
    chk("pin_c_addr0", q_addr[0], 32'h1000);
    chk("pin_c_strb0", q_strb[0], 64'hFFFF_FFFF_FFFF_0000);
    chk("pin_c_addr1", q_addr[1], 32'h1040);
    chk("pin_c_strb1", q_strb[1], 64'h000F_FFFF_FFFF_FFFF);
    clear_q();

    rdy_mode = 0;
    run_desc(32'h1000, 32'd4096, 1'b0);
    run_desc(32'h1F80, 32'd256, 1'b0);
    run_desc(32'h1010, 32'd100, 1'b0);
    run_desc(32'h2000, 32'd0, 1'b0);
    run_desc(32'hFFFF_FFD0, 32'd300, 1'b0);

    // Backpressure: hold ready low for 5 cycles of a valid request.
    rdy_mode = 2;
    req_ready_i = 1'b0;
    src_addr_i = 32'h1000;
    num_bytes_i = 32'd256;
    start_i = 1'b1;
    step();
    k = 0;
    while (m_phase != 2 && k < 10) begin
      step();
      k++;
    end
    repeat (5) step();
    chk("bp_valid", req_valid_o, 1'b1);
    chk("bp_addr", req_addr_o, 32'h1000);
    chk("bp_alen", req_alen_o, 8'd3);
    req_ready_i = 1'b1;
    wait_idle(20, 1'b0);

    // Reset in the middle of a multi-request transfer.
    rdy_mode = 1;
    src_addr_i = 32'h3000;
    num_bytes_i = 32'd32768;
    start_i = 1'b1;
    step();
    repeat (6) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_valid", req_valid_o, 1'b0);
    chk("mid_rst_busy", busy_o, 1'b0);
    chk("mid_rst_addr", req_addr_o, 32'h0);
    chk("mid_rst_strb", req_strb_o, 64'h0);
    step();

    for (int i = 0; i < 80; i++) begin
      k = $urandom_range(0, 9);
      a = $urandom;
      if ($urandom_range(0, 2) == 0) a = a & ~32'(BYTES - 1);
      if ($urandom_range(0, 9) == 0) a = 32'hFFFF_F000 | (a & 32'hFFF);
      if (k == 0) n = 0;
      else if (k <= 5) n = $urandom_range(1, 200);
      else if (k <= 8) n = $urandom_range(1, 20000);
      else n = BYTES * $urandom_range(1, 300);
      rdy_mode = ($urandom_range(0, 3) == 0) ? 0 : 1;
      run_desc(a, n, 1'b1);
    end

`ifdef DMA_RD_STREAMER_ABORT_EN
    model_en = 1'b0;
    rdy_mode = 2;
    req_ready_i = 1'b0;
    src_addr_i = 32'h0;
    num_bytes_i = 32'd16384;
    start_i = 1'b1;
    step();
    k = 0;
    while (!req_valid_o && k < 10) begin
      step();
      k++;
    end
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    repeat (3) begin
      chk("abort_hold_valid", req_valid_o, 1'b1);
      chk("abort_hold_aborted", aborted_o, 1'b0);
      step();
    end
    req_ready_i = 1'b1;
    step();
    req_ready_i = 1'b0;
    chk("abort_valid", req_valid_o, 1'b0);
    chk("abort_busy", busy_o, 1'b0);
    chk("abort_pulse", aborted_o, 1'b1);
    chk("abort_no_done", done_o, 1'b0);
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
